// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell built from two half adders,
// processing a WIDTH-bit operand pair LSB first with a start/busy/done handshake.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [CNT_W-1:0]   bit_cnt;
    logic               carry;

    logic               accept;
    logic               last_bit;
    logic               p;
    logic               g1;
    logic               s;
    logic               g2;
    logic               carry_nxt;
    logic [WIDTH-1:0]   res_nxt;

    // Full-adder cell as two cascaded half adders
    always_comb begin
        p         = a_sr[0] ^ b_sr[0];
        g1        = a_sr[0] & b_sr[0];
        s         = p ^ carry;
        g2        = p & carry;
        carry_nxt = g1 | g2;
        res_nxt   = {s, res_sr[WIDTH-1:1]};
        last_bit  = (bit_cnt == CNT_W'(WIDTH - 1));
        accept    = start && (state != RUN);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last_bit) state_nxt = DONE;
            DONE: state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            bit_cnt <= '0;
            carry   <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (accept) begin
                // Subtract is a + ~b + 1: invert B on load and force the carry in
                a_sr    <= a;
                b_sr    <= mode ? ~b : b;
                carry   <= mode ? 1'b1 : cin;
                bit_cnt <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                carry  <= carry_nxt;
                res_sr <= res_nxt;
                if (last_bit) begin
                    // carry still holds the carry into the MSB here
                    sum  <= res_nxt;
                    cout <= carry_nxt;
                    ovf  <= carry ^ carry_nxt;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized operations
// checked against an integer-arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic on the operands
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tc, input logic tm);
        int ua, ub, sa, sb, u, sr;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        if (!tm) begin
            u        = ua + ub + int'(tc);
            sr       = sa + sb + int'(tc);
            exp_cout = (u >= (1 << W));
        end else begin
            u        = ua - ub;
            sr       = sa - sb;
            exp_cout = (ua >= ub);
        end
        exp_sum = W'(u);
        exp_ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endtask

    // Called at a negedge; start is accepted at the following posedge
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic tm);
        a = ta; b = tb_v; cin = tc; mode = tm; start = 1'b1;
        model(ta, tb_v, tc, tm);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); mode = 1'($urandom);
        chk("accept_busy_nodone", {30'd0, busy, done}, 32'h2);
    endtask

    // Waits for done (bounded), checks latency, busy shape, held outputs and result
    task automatic finish(input string tag, input int exp_lat);
        int n, bad_busy, chg, both;
        n = 0; bad_busy = 0; chg = 0; both = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) bad_busy++;
            if (busy && done) both++;
            if (sum !== prev_sum || cout !== prev_cout || ovf !== prev_ovf) chg++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_busy_run"}, bad_busy, 0);
        chk({tag, "_busy_done_overlap"}, both, 0);
        chk({tag, "_outputs_held"}, chg, 0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
        prev_sum = exp_sum; prev_cout = exp_cout; prev_ovf = exp_ovf;
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;

        // Reset with random inputs for two cycles
        repeat (2) begin
            @(negedge clk);
            start = 1'($urandom); a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); mode = 1'($urandom);
        end
        @(negedge clk);
        chk("reset_outputs", {19'd0, busy, done, sum, cout, ovf}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {19'd0, busy, done, sum, cout, ovf}, 32'd0);

        // Directed arithmetic cases
        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        finish("add_5a_3c", W);
        chk("add_5a_3c_const", {23'd0, sum, cout}, {23'd0, 8'h96, 1'b0});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);

        launch(8'hFF, 8'h01, 1'b1, 1'b0);
        finish("add_carry", W);
        @(negedge clk);
        launch(8'h10, 8'h20, 1'b1, 1'b1);
        finish("sub_borrow", W);
        chk("sub_10_20_const", {22'd0, sum, cout, ovf}, {22'd0, 8'hF0, 2'b00});
        @(negedge clk);
        launch(8'h80, 8'h01, 1'b0, 1'b1);
        finish("sub_ovf", W);
        chk("sub_80_01_const", {22'd0, sum, cout, ovf}, {22'd0, 8'h7F, 2'b11});

        // Start during RUN must be ignored
        @(negedge clk);
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        finish("ignore_start", W - 3);
        @(negedge clk);
        chk("no_second_op", {30'd0, busy, done}, 0);

        // Back-to-back: start held in the DONE cycle
        launch(8'h33, 8'h44, 1'b1, 1'b0);
        finish("b2b_first", W);
        launch(8'h07, 8'h09, 1'b0, 1'b1);
        finish("b2b_second", W);

        // Randomized operations, some back-to-back
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            launch(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            finish("rand_op", W);
        end

        // Reset in the middle of an operation
        @(negedge clk);
        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrun_reset", {19'd0, busy, done, sum, cout, ovf}, 32'd0);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("no_done_after_abort", dn, 0);
        chk("sum_lost_after_abort", {24'd0, sum}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor. It uses one full-adder cell, built from two half-adder stages, to process a WIDTH-bit operand pair one bit per clock, LSB first. It is the sequential, multi-bit successor to the team's single-bit half adder and serves area-constrained datapaths that can tolerate WIDTH-cycle latency. A start/busy/done handshake controls operation, and the result is held stable between operations.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when the block is not busy.
- mode  in  1  0 = add (a + b + cin); 1 = subtract (a - b, i.e. a + ~b + 1, cin ignored).
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- cin  in  1  carry-in for add; captured on an accepted start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  WIDTH  result; updated only on completion, held otherwise.
- cout  out  1  carry-out; in subtract mode, 1 = no borrow.
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Reset (rst_n low at a clock edge): state = IDLE; busy, done, sum, cout and ovf all = 0; internal shift registers and bit counter cleared. Reset takes priority over every other input.
- FSM states:
  - IDLE: accepts start.
  - RUN: processes one bit per cycle.
  - DONE: publishes the result for one cycle, then returns to IDLE.
- IDLE/DONE + start=1:
  - a is captured into the A shift register.
  - b (mode=0) or ~b (mode=1) is captured into the B shift register.
  - Carry register = cin (mode=0) or 1 (mode=1).
  - Bit counter = 0; go to RUN.
- IDLE + start=0: stay in IDLE.
- DONE + start=0: go to IDLE.
- RUN, each cycle:
  - Half adder 1: p = A[0] ^ B[0], g1 = A[0] & B[0].
  - Half adder 2: s = p ^ carry, g2 = p & carry.
  - carry <= g1 | g2.
  - A and B shift right by one.
  - s shifts into the MSB of the internal result register.
  - When the counter reaches WIDTH-1:
    - The previous carry (carry into the MSB) is kept for ovf.
    - sum <= result register with the final bit included; cout <= new carry; ovf <= carry-in-to-MSB ^ new carry.
    - Go to DONE.
  - Otherwise the counter increments.
- start while in RUN is ignored and has no effect on the operation in flight.
- a, b, cin and mode are don't-care except in the cycle where start is accepted.
- sum, cout and ovf never change except at completion or reset.

## Timing
- Start accepted at edge E0 → busy = 1 from E0 through E(WIDTH); done = 1 for exactly the one cycle following E(WIDTH); sum/cout/ovf valid from E(WIDTH).
- Latency from accepted start to done = WIDTH cycles. For WIDTH=8, done rises 8 edges after the accepted start.
- busy and done are never high together.
- Back-to-back operation: start held in the DONE cycle is accepted. busy rises at the next edge, giving a throughput of one result per WIDTH+1 cycles.
- Reset asserted mid-RUN:
  - The next edge clears busy and all outputs.
  - No done pulse is issued for the aborted operation.
  - The previous result is lost (sum = 0).
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with random inputs → busy = done = sum = cout = ovf = 0. Release with start = 0 → outputs stay 0.
- Add, WIDTH=8: a=0x5A, b=0x3C, cin=0, mode=0 → done 8 cycles after start; sum=0x96, cout=0, ovf=1. busy is high for exactly 8 cycles.
- Add with carry: a=0xFF, b=0x01, cin=1, mode=0 → sum=0x01, cout=1, ovf=0.
- Subtract: a=0x10, b=0x20, mode=1, cin=1 → sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1.
- Handshake:
  - Pulse start with a=0x01, b=0x01; 3 cycles later pulse start with a=0xAA, b=0x55 → the second start is ignored and the result is sum=0x02.
  - Holding start in the DONE cycle launches the next operation with no idle cycle.
- Reset mid-operation: start a=0x5A, b=0x3C; drop rst_n for one edge at cycle 3 → busy = 0 and sum = 0 after that edge; no done pulse within 20 cycles.
